cv32e40p_instr_aligner_tmr: RTL and testbench
=============================================

Name: cv32e40p_instr_aligner_tmr

Overview:
- Upstream neighbour of the fault-tolerant compressed decoder.
- Takes 32-bit word-aligned fetch words from the prefetch buffer and extracts halfword-aligned instructions: 16-bit compressed instructions, and 32-bit instructions that may straddle two fetch words.
- Drives each aligned instruction, unchanged, onto three identical lanes feeding the triplicated decoder inputs, and tracks the PC of the presented instruction.
- Uses a valid/ready handshake on both sides and handles branch redirects.

Parameters:
- RESET_PC, 32'h0000_0080, PC loaded on reset.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, reset is synchronous and active-low.
- fetch_valid_i  in  1  fetch_rdata_i is valid.
- fetch_ready_o  out  1  current fetch word is consumed this cycle (consumed when fetch_valid_i & fetch_ready_o).
- fetch_rdata_i  in  32  word-aligned fetch data.
- branch_i  in  1  redirect request, single-cycle pulse.
- branch_addr_i  in  32  redirect target; bit0 ignored.
- instr_valid_o  out  1  aligned instruction available.
- instr_ready_i  in  1  downstream accepts (accepted when instr_valid_o & instr_ready_i).
- instr_aligned_o  out  [2:0][31:0]  aligned instruction; all three lanes always equal.
- pc_o  out  32  PC of the instruction on instr_aligned_o.

Behaviour:
- Registers: state {ALIGNED, HALF, BRANCH_MIS}, pc_q[31:0], half_q[15:0].
- All register updates happen on the rising clk edge.
- Reset (rst_n=0 at edge): state=ALIGNED, pc_q=RESET_PC, half_q=0.
- While rst_n=0: instr_valid_o=0 and fetch_ready_o=0, combinationally forced. instr_aligned_o and pc_o are don't-care.
- pc_o = pc_q. Compressed outputs are zero-extended ({16'h0, hw}).
- Branch has priority over everything. In a branch_i=1 cycle:
  - instr_valid_o=0, fetch_ready_o=0.
  - Next edge: pc_q={branch_addr_i[31:1],1'b0}, half_q discarded.
  - Next state: BRANCH_MIS if branch_addr_i[1]=1, else ALIGNED.
  - A branch coincident with reset is ignored; reset wins.
- ALIGNED (halfword offset 0):
  - instr_valid_o=fetch_valid_i.
  - If fetch_rdata_i[1:0]==2'b11: instr=fetch_rdata_i, fetch_ready_o=instr_ready_i. On accept: pc_q+=4, stay ALIGNED.
  - Else: instr={16'h0,fetch_rdata_i[15:0]}, fetch_ready_o=instr_ready_i. On accept: half_q=fetch_rdata_i[31:16], pc_q+=2, go HALF.
- HALF (upper half of the previous word buffered in half_q):
  - If half_q[1:0]!=2'b11 (compressed): instr={16'h0,half_q}, instr_valid_o=1 independent of fetch_valid_i, fetch_ready_o=0. On accept: pc_q+=2, go ALIGNED.
  - If half_q[1:0]==2'b11 (straddling 32-bit): instr={fetch_rdata_i[15:0],half_q}, instr_valid_o=fetch_valid_i, fetch_ready_o=instr_ready_i. On accept: half_q=fetch_rdata_i[31:16], pc_q+=4, stay HALF.
- BRANCH_MIS:
  - instr_valid_o=0, fetch_ready_o=1.
  - When fetch_valid_i=1: half_q=fetch_rdata_i[31:16], go HALF; the lower half is discarded.
  - This costs exactly one bubble per misaligned branch target.
- Stability: while instr_valid_o=1 and instr_ready_i=0 with no branch, instr_aligned_o and pc_o hold constant. Upstream holds fetch_rdata_i stable while unconsumed.
- A word is never consumed without either producing an accepted instruction or being buffered (or, in BRANCH_MIS, having its upper half buffered).
- Arithmetic: pc_q increments are mod 2^32. Wrap from 32'hFFFF_FFFE+2 gives 0 and is not flagged.
- Latency: combinational from fetch data to instr_aligned_o. Register state changes take effect the cycle after accept.

Test Plan:
- Reset, fetch word 32'h0000_0013 valid, ready=1 -> instr=32'h0000_0013 on all lanes, pc_o=0x80 then 0x84, fetch_ready_o=1.
- Words 32'h4501_4485 then 32'h0000_0013 -> outputs 0x4485 (pc 0x80), 0x4501 (pc 0x82, fetch_ready_o=0), 0x00000013 (pc 0x84).
- Word 32'h0513_4485 then 32'h0010_0000 -> 0x4485 (pc 0x80), then straddling 32'h0000_0513 (pc 0x82), HALF retained with half_q=0x0010.
- Branch to 0x102, word 32'h4505_1234 -> one bubble, then 0x4505 at pc 0x102; branch asserted while instr_valid_o=1 & ready=0 -> valid drops in that cycle, buffered half discarded.
- instr_ready_i=0 for 5 cycles with a straddling instruction pending -> outputs and pc_o stable, fetch_ready_o=0.
- Assert rst_n=0 while in HALF -> next cycle state ALIGNED, pc_o=0x80, no stale half emitted; randomized lane check that lanes [0], [1] and [2] are always equal.

Source files
------------

// File: rtl/cv32e40p_instr_aligner_tmr.sv
// Instruction aligner: extracts halfword-aligned 16/32-bit instructions from
// word-aligned fetch data and presents each one on three identical lanes.
module cv32e40p_instr_aligner_tmr #(
    parameter logic [31:0] RESET_PC = 32'h0000_0080
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_valid_i,
    output logic             fetch_ready_o,
    input  logic [31:0]      fetch_rdata_i,
    input  logic             branch_i,
    input  logic [31:0]      branch_addr_i,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    output logic [2:0][31:0] instr_aligned_o,
    output logic [31:0]      pc_o
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned HLEN = 16;

    typedef enum logic [1:0] {
        ALIGNED    = 2'd0,
        HALF       = 2'd1,
        BRANCH_MIS = 2'd2
    } state_t;

    state_t            state_q, state_nxt;
    logic [XLEN-1:0]   pc_q, pc_nxt;
    logic [HLEN-1:0]   half_q, half_nxt;
    logic [XLEN-1:0]   instr;
    logic              instr_valid;
    logic              fetch_ready;
    logic              accept;

    // Instruction extraction, handshake and next-state selection.
    always_comb begin
        state_nxt   = state_q;
        pc_nxt      = pc_q;
        half_nxt    = half_q;
        instr       = '0;
        instr_valid = 1'b0;
        fetch_ready = 1'b0;
        accept      = 1'b0;

        unique case (state_q)
            ALIGNED: begin
                instr_valid = fetch_valid_i;
                fetch_ready = instr_ready_i;
                accept      = fetch_valid_i & instr_ready_i;
                if (fetch_rdata_i[1:0] == 2'b11) begin
                    instr = fetch_rdata_i;
                    if (accept) begin
                        pc_nxt = pc_q + XLEN'(4);
                    end
                end else begin
                    instr = {16'h0, fetch_rdata_i[15:0]};
                    if (accept) begin
                        half_nxt  = fetch_rdata_i[31:16];
                        pc_nxt    = pc_q + XLEN'(2);
                        state_nxt = HALF;
                    end
                end
            end
            HALF: begin
                if (half_q[1:0] != 2'b11) begin
                    // Buffered compressed instruction needs no new fetch data.
                    instr       = {16'h0, half_q};
                    instr_valid = 1'b1;
                    accept      = instr_ready_i;
                    if (accept) begin
                        pc_nxt    = pc_q + XLEN'(2);
                        state_nxt = ALIGNED;
                    end
                end else begin
                    // 32-bit instruction straddling the buffered half and the new word.
                    instr       = {fetch_rdata_i[15:0], half_q};
                    instr_valid = fetch_valid_i;
                    fetch_ready = instr_ready_i;
                    accept      = fetch_valid_i & instr_ready_i;
                    if (accept) begin
                        half_nxt = fetch_rdata_i[31:16];
                        pc_nxt   = pc_q + XLEN'(4);
                    end
                end
            end
            BRANCH_MIS: begin
                // Drop the lower half of the target word; keep the upper half.
                fetch_ready = 1'b1;
                if (fetch_valid_i) begin
                    half_nxt  = fetch_rdata_i[31:16];
                    state_nxt = HALF;
                end
            end
            default: begin
                state_nxt = ALIGNED;
            end
        endcase

        if (branch_i) begin
            instr_valid = 1'b0;
            fetch_ready = 1'b0;
            pc_nxt      = branch_addr_i & 32'hFFFF_FFFE;
            half_nxt    = '0;
            state_nxt   = branch_addr_i[1] ? BRANCH_MIS : ALIGNED;
        end

        if (!rst_n) begin
            instr_valid = 1'b0;
            fetch_ready = 1'b0;
        end
    end

    // State, PC and halfword buffer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ALIGNED;
            pc_q    <= RESET_PC;
            half_q  <= '0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            half_q  <= half_nxt;
        end
    end

    assign instr_aligned_o = {instr, instr, instr};
    assign instr_valid_o   = instr_valid;
    assign fetch_ready_o   = fetch_ready;
    assign pc_o            = pc_q;

endmodule

// File: tb/tb_cv32e40p_instr_aligner_tmr.sv
// Directed self-checking bench for the triplicated instruction aligner.
module tb_cv32e40p_instr_aligner_tmr;

    logic             clk;
    logic             rst_n;
    logic             fetch_valid_i;
    logic             fetch_ready_o;
    logic [31:0]      fetch_rdata_i;
    logic             branch_i;
    logic [31:0]      branch_addr_i;
    logic             instr_valid_o;
    logic             instr_ready_i;
    logic [2:0][31:0] instr_aligned_o;
    logic [31:0]      pc_o;

    int checks = 0;
    int passed = 0;

    cv32e40p_instr_aligner_tmr #(.RESET_PC(32'h0000_0080)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_valid_i  (fetch_valid_i),
        .fetch_ready_o  (fetch_ready_o),
        .fetch_rdata_i  (fetch_rdata_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .instr_valid_o  (instr_valid_o),
        .instr_ready_i  (instr_ready_i),
        .instr_aligned_o(instr_aligned_o),
        .pc_o           (pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_instr(input string tag, input logic [31:0] exp);
        chk({tag, " lane0"}, instr_aligned_o[0], exp);
        chk({tag, " lane1"}, instr_aligned_o[1], exp);
        chk({tag, " lane2"}, instr_aligned_o[2], exp);
    endtask

    task automatic chk_hs(input string tag, input logic v, input logic fr);
        chk({tag, " valid"}, 32'(instr_valid_o), 32'(v));
        chk({tag, " fetch_ready"}, 32'(fetch_ready_o), 32'(fr));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        branch_i      = 1'b0;
        fetch_valid_i = 1'b1;
        instr_ready_i = 1'b1;
        #1;
        chk_hs("in_reset", 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        fetch_valid_i = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] model_pc;
        logic [31:0] w;

        rst_n         = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_rdata_i = '0;
        branch_i      = 1'b0;
        branch_addr_i = '0;
        instr_ready_i = 1'b0;
        step();

        // Aligned 32-bit instruction
        do_reset();
        chk("reset_pc", pc_o, 32'h80);
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0000_0013; instr_ready_i = 1'b1; #1;
        chk_instr("t1", 32'h0000_0013);
        chk("t1 pc", pc_o, 32'h80);
        chk_hs("t1", 1'b1, 1'b1);
        step();
        chk("t1 pc_after", pc_o, 32'h84);

        // Two compressed, then aligned 32-bit
        do_reset();
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h4501_4485; #1;
        chk_instr("t2a", 32'h0000_4485);
        chk("t2a pc", pc_o, 32'h80);
        chk_hs("t2a", 1'b1, 1'b1);
        step();
        fetch_rdata_i = 32'h0000_0013; #1;
        chk_instr("t2b", 32'h0000_4501);
        chk("t2b pc", pc_o, 32'h82);
        chk_hs("t2b", 1'b1, 1'b0);
        step();
        chk_instr("t2c", 32'h0000_0013);
        chk("t2c pc", pc_o, 32'h84);
        chk_hs("t2c", 1'b1, 1'b1);
        step();
        chk("t2 pc_after", pc_o, 32'h88);

        // Compressed then straddling 32-bit, with a 5-cycle stall
        do_reset();
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0513_4485; #1;
        chk_instr("t3a", 32'h0000_4485);
        step();
        fetch_rdata_i = 32'h0010_0000; instr_ready_i = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            chk_instr("stall", 32'h0000_0513);
            chk("stall pc", pc_o, 32'h82);
            chk_hs("stall", 1'b1, 1'b0);
            step();
        end
        instr_ready_i = 1'b1; #1;
        chk_instr("t3b", 32'h0000_0513);
        chk_hs("t3b", 1'b1, 1'b1);
        step();
        fetch_valid_i = 1'b0; #1;
        chk_instr("t3c half", 32'h0000_0010);
        chk("t3c pc", pc_o, 32'h86);
        chk_hs("t3c", 1'b1, 1'b0);

        // Branch while stalled on a buffered half, to a misaligned target
        instr_ready_i = 1'b0; branch_i = 1'b1; branch_addr_i = 32'h0000_0102; #1;
        chk_hs("br_cycle", 1'b0, 1'b0);
        step();
        branch_i = 1'b0; instr_ready_i = 1'b1;
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h4505_1234; #1;
        chk("br pc", pc_o, 32'h102);
        chk_hs("br_bubble", 1'b0, 1'b1);
        step();
        fetch_valid_i = 1'b0; #1;
        chk_instr("br_tgt", 32'h0000_4505);
        chk("br_tgt pc", pc_o, 32'h102);
        chk_hs("br_tgt", 1'b1, 1'b0);
        step();
        chk("br_next pc", pc_o, 32'h104);
        chk_hs("br_next", 1'b0, 1'b1);

        // Aligned branch target, bit 0 ignored
        branch_i = 1'b1; branch_addr_i = 32'h0000_0201; #1;
        step();
        branch_i = 1'b0; fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0000_0013; #1;
        chk("br2 pc", pc_o, 32'h200);
        chk_instr("br2", 32'h0000_0013);
        chk_hs("br2", 1'b1, 1'b1);

        // Reset while in HALF: no stale half afterwards
        do_reset();
        fetch_valid_i = 1'b1; fetch_rdata_i = 32'h0513_4485; #1;
        step();
        rst_n = 1'b0; fetch_rdata_i = 32'h0000_0013; #1;
        chk_hs("rst_half", 1'b0, 1'b0);
        step();
        rst_n = 1'b1; #1;
        chk("rst_half pc", pc_o, 32'h80);
        chk_instr("rst_half", 32'h0000_0013);
        chk_hs("rst_half_after", 1'b1, 1'b1);

        // PC wrap
        branch_i = 1'b1; branch_addr_i = 32'hFFFF_FFFC; #1;
        step();
        branch_i = 1'b0; #1;
        chk("wrap pc0", pc_o, 32'hFFFF_FFFC);
        step();
        chk("wrap pc1", pc_o, 32'h0000_0000);

        // Random aligned 32-bit words: lanes equal the word, PC advances by 4
        model_pc = 32'h0;
        for (int i = 0; i < 8; i++) begin
            w = $urandom | 32'h3;
            fetch_rdata_i = w; #1;
            chk_instr("rand", w);
            chk("rand pc", pc_o, model_pc);
            step();
            model_pc = model_pc + 32'd4;
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
